// File: rtl/instr_encoder.sv
// RV32I field packer: validates a decoded field bundle, encodes it per instruction format and
// queues the word, tagged with a running word address, in a small output FIFO.
module instr_encoder #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [6:0]        opcode,
    input  logic [2:0]        f3,
    input  logic [6:0]        f7,
    input  logic [4:0]        srcRegister1,
    input  logic [4:0]        srcRegister2,
    input  logic [4:0]        desRegister,
    input  logic [XLEN-1:0]   imm,
    input  logic              loadBase,
    input  logic [ADDR_W-1:0] baseAddr,
    output logic              outValid,
    input  logic              outReady,
    output logic [XLEN-1:0]   outInstr,
    output logic [ADDR_W-1:0] outAddr,
    output logic              errValid,
    output logic [2:0]        errCode,
    output logic [7:0]        errCount
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_OPCODE = 3'd1;
    localparam logic [2:0] ERR_RANGE  = 3'd2;
    localparam logic [2:0] ERR_ALIGN  = 3'd3;
    localparam logic [2:0] ERR_SHAMT  = 3'd4;

    localparam logic signed [XLEN-1:0] I_MIN = XLEN'(-2048);
    localparam logic signed [XLEN-1:0] I_MAX = XLEN'(2047);
    localparam logic signed [XLEN-1:0] B_MIN = XLEN'(-4096);
    localparam logic signed [XLEN-1:0] B_MAX = XLEN'(4094);
    localparam logic signed [XLEN-1:0] J_MIN = XLEN'(-1048576);
    localparam logic signed [XLEN-1:0] J_MAX = XLEN'(1048574);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    fmt_e                    fmt;
    logic signed [XLEN-1:0]  imm_s;
    logic                    is_shift;
    logic [XLEN-1:0]         enc_word;
    logic [2:0]              enc_err;

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [ADDR_W-1:0]       word_addr;

    logic [XLEN-1:0]         instr_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]       addr_mem_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    err_valid_q, err_valid_d;
    logic [2:0]              err_code_q, err_code_d;
    logic [7:0]              err_count_q, err_count_d;

    assign imm_s    = $signed(imm);
    assign is_shift = (opcode == OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101));

    always_comb begin
        fmt = FMT_BAD;
        unique case (opcode)
            OP_R:                                  fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   fmt = FMT_I;
            OP_STORE:                              fmt = FMT_S;
            OP_BRANCH:                             fmt = FMT_B;
            OP_LUI, OP_AUIPC:                      fmt = FMT_U;
            OP_JAL:                                fmt = FMT_J;
            default:                               fmt = FMT_BAD;
        endcase
    end

    // Range is checked before alignment, so an odd out-of-range offset reports code 2.
    always_comb begin
        enc_word = '0;
        enc_err  = ERR_NONE;
        case (fmt)
            FMT_R: begin
                enc_word = {f7, srcRegister2, srcRegister1, f3, desRegister, opcode};
            end
            FMT_I: begin
                if (is_shift) begin
                    if (imm[XLEN-1:5] != '0) enc_err = ERR_SHAMT;
                    enc_word = {f7, imm[4:0], srcRegister1, f3, desRegister, opcode};
                end else begin
                    if ((imm_s < I_MIN) || (imm_s > I_MAX)) enc_err = ERR_RANGE;
                    enc_word = {imm[11:0], srcRegister1, f3, desRegister, opcode};
                end
            end
            FMT_S: begin
                if ((imm_s < I_MIN) || (imm_s > I_MAX)) enc_err = ERR_RANGE;
                enc_word = {imm[11:5], srcRegister2, srcRegister1, f3, imm[4:0], opcode};
            end
            FMT_B: begin
                if ((imm_s < B_MIN) || (imm_s > B_MAX)) enc_err = ERR_RANGE;
                else if (imm[0])                         enc_err = ERR_ALIGN;
                enc_word = {imm[12], imm[10:5], srcRegister2, srcRegister1, f3,
                            imm[4:1], imm[11], opcode};
            end
            FMT_U: begin
                if (imm[11:0] != 12'd0) enc_err = ERR_RANGE;
                enc_word = {imm[31:12], desRegister, opcode};
            end
            FMT_J: begin
                if ((imm_s < J_MIN) || (imm_s > J_MAX)) enc_err = ERR_RANGE;
                else if (imm[0])                         enc_err = ERR_ALIGN;
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], desRegister, opcode};
            end
            default: begin
                enc_err = ERR_OPCODE;
            end
        endcase
    end

    assign outValid  = (count_q != '0);
    assign inReady   = (count_q != DEPTH_C) || outReady;
    assign accept    = inValid && inReady;
    assign push      = accept && (enc_err == ERR_NONE);
    assign pop       = outValid && outReady;
    assign word_addr = loadBase ? baseAddr : addr_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (push)          addr_d = word_addr + ADDR_W'(1);
        else if (loadBase) addr_d = baseAddr;

        if (accept && (enc_err != ERR_NONE)) begin
            err_valid_d = 1'b1;
            err_code_d  = enc_err;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                addr_mem_q[i]  <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_count_q <= 8'd0;
        end else begin
            if (push) begin
                instr_mem_q[wr_ptr_q] <= enc_word;
                addr_mem_q[wr_ptr_q]  <= word_addr;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

    assign outInstr = instr_mem_q[rd_ptr_q];
    assign outAddr  = addr_mem_q[rd_ptr_q];
    assign errValid = err_valid_q;
    assign errCode  = err_code_q;
    assign errCount = err_count_q;

endmodule
